// File: rtl/riscv_muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic signed_a(md_op_e op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic signed_b(md_op_e op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// Request/response handshake between the datapath and the multiply/divide unit.
interface riscv_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              busy;

  modport master (
    output in_valid, funct3, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/riscv_muldiv.sv
// Radix-2 iterative multiply/divide engine; one shared 2*DATA_W shift register
// holds {acc_hi, multiplier} for multiply and {remainder, quotient} for divide.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction and result selection, result registered
// DONE  | result held until out_ready
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           reset,
  riscv_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

  state_e              state, state_nxt;
  md_op_e              op_q;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opd_q;
  logic [DATA_W-1:0]   result_q;
  logic [CNT_W-1:0]    count;
  logic                neg_q;
  logic                special_q;
  logic                out_valid_q;

  md_op_e              op_in;
  logic                accept, sign_a, sign_b, neg_in;
  logic                div_zero, div_ovf, mul_zero, special_in;
  logic [DATA_W-1:0]   mag_a, mag_b, special_val;
  logic [DATA_W:0]     mul_sum, div_r, div_diff;
  logic [2*DATA_W-1:0] mul_next, div_next, prod;
  logic [DATA_W-1:0]   quo, rem, fix_res;
  logic                last_iter;

  assign op_in      = md_op_e'(bus.funct3);
  assign accept     = bus.in_valid & (state == IDLE) & ~bus.flush;
  assign sign_a     = signed_a(op_in) & bus.op_a[DATA_W-1];
  assign sign_b     = signed_b(op_in) & bus.op_b[DATA_W-1];
  assign mag_a      = sign_a ? -bus.op_a : bus.op_a;
  assign mag_b      = sign_b ? -bus.op_b : bus.op_b;
  assign neg_in     = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);

  assign div_zero   = is_div(op_in) & (bus.op_b == '0);
  assign div_ovf    = ((op_in == DIV) || (op_in == REM)) & (bus.op_a == MIN_INT) & (bus.op_b == '1);
  assign mul_zero   = ~is_div(op_in) & ((bus.op_a == '0) | (bus.op_b == '0));
  assign special_in = div_zero | div_ovf | mul_zero;

  always_comb begin
    special_val = '0;
    if (div_zero) begin
      special_val = is_rem(op_in) ? bus.op_a : '1;
    end else if (div_ovf) begin
      special_val = is_rem(op_in) ? '0 : MIN_INT;
    end
  end

  // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc[DATA_W-1:1]};

  // Divide: trial-subtract the divisor from the shifted partial remainder; keep it if non-negative.
  assign div_r    = acc[2*DATA_W-1:DATA_W-1];
  assign div_diff = div_r - {1'b0, opd_q};
  assign div_next = div_diff[DATA_W] ? {div_r[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

  assign last_iter = (count == CNT_W'(DATA_W - 1));

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem  = neg_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  always_comb begin
    fix_res = '0;
    if (special_q) begin
      fix_res = acc[DATA_W-1:0];
    end else begin
      case (op_q)
        MUL:                 fix_res = prod[DATA_W-1:0];
        MULH, MULHSU, MULHU: fix_res = prod[2*DATA_W-1:DATA_W];
        DIV, DIVU:           fix_res = quo;
        default:             fix_res = rem;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state_nxt = special_in ? FIX : CALC;
        CALC: if (last_iter) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (out_valid_q && bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= MUL;
      acc         <= '0;
      opd_q       <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      special_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= op_in;
            neg_q     <= neg_in;
            special_q <= special_in;
            count     <= '0;
            if (special_in) begin
              acc   <= {{DATA_W{1'b0}}, special_val};
              opd_q <= '0;
            end else if (is_div(op_in)) begin
              acc   <= {{DATA_W{1'b0}}, mag_a};
              opd_q <= mag_b;
            end else begin
              acc   <= {{DATA_W{1'b0}}, mag_b};
              opd_q <= mag_a;
            end
          end
        end
        CALC: begin
          acc   <= is_div(op_q) ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          if (!bus.flush) result_q <= fix_res;
        end
        default: ;
      endcase
      // out_valid is registered, so it rises one cycle after DONE is entered.
      out_valid_q <= (state == DONE) & ~bus.flush & ~(out_valid_q & bus.out_ready);
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == CALC) || (state == DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Bench for riscv_muldiv at DATA_W = 32 and 64: directed table, corner sequences, random vs model.
module tb_riscv_muldiv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_muldiv_if #(.DATA_W(32)) bus32 ();
  riscv_muldiv_if #(.DATA_W(64)) bus64 ();

  riscv_muldiv #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  riscv_muldiv #(.DATA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      bus32.in_valid = v; bus32.funct3 = f; bus32.op_a = a[31:0]; bus32.op_b = b[31:0];
    end else begin
      bus64.in_valid = v; bus64.funct3 = f; bus64.op_a = a; bus64.op_b = b;
    end
  endtask

  task automatic set_flush(input int w, input logic v);
    if (w == 32) bus32.flush = v; else bus64.flush = v;
  endtask

  task automatic set_oready(input int w, input logic v);
    if (w == 32) bus32.out_ready = v; else bus64.out_ready = v;
  endtask

  function automatic logic ov(input int w);
    return (w == 32) ? bus32.out_valid : bus64.out_valid;
  endfunction

  function automatic logic rd(input int w);
    return (w == 32) ? bus32.in_ready : bus64.in_ready;
  endfunction

  function automatic logic bsy(input int w);
    return (w == 32) ? bus32.busy : bus64.busy;
  endfunction

  function automatic logic [63:0] res(input int w);
    return (w == 32) ? {32'b0, bus32.result} : bus64.result;
  endfunction

  // Reference: wide plain arithmetic on sign/zero-extended operands.
  function automatic logic [63:0] model(input int w, input logic [2:0] f,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ua, ub, mask, r;
    logic signed [127:0] sa, sb, p;
    mask = (w == 32) ? 128'hFFFF_FFFF : 128'hFFFF_FFFF_FFFF_FFFF;
    ua = {64'b0, a} & mask;
    ub = {64'b0, b} & mask;
    sa = (w == 32) ? {{96{a[31]}}, a[31:0]} : {{64{a[63]}}, a};
    sb = (w == 32) ? {{96{b[31]}}, b[31:0]} : {{64{b[63]}}, b};
    r = '0;
    case (f)
      3'd0: r = ua * ub;
      3'd1: begin p = sa * sb; r = p >> w; end
      3'd2: begin p = sa * $signed(ub); r = p >> w; end
      3'd3: r = (ua * ub) >> w;
      3'd4: if (ub == 0) r = mask; else begin p = sa / sb; r = p; end
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: if (ub == 0) r = ua; else begin p = sa % sb; r = p; end
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[63:0];
  endfunction

  function automatic int exp_lat(input int w, input logic [2:0] f,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mn, ones;
    mn   = 64'h1 << (w - 1);
    ones = (w == 32) ? 64'hFFFF_FFFF : '1;
    if (f[2] && b == 0) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == mn && b == ones) return 2;
    if (!f[2] && (a == 0 || b == 0)) return 2;
    return w + 2;
  endfunction

  function automatic logic [63:0] rand_opnd(input int w);
    logic [63:0] v;
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: v = '0;
      1: v = '1;
      2: v = 64'h1 << (w - 1);
      3: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    if (w == 32) v[63:32] = '0;
    return v;
  endfunction

  // Issue one request, wait for out_valid (bounded), optionally hold off out_ready, then handshake.
  task automatic run(input int w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                     input int hold, output logic [63:0] r, output int lat, output logic rdy_seen);
    @(negedge clk);
    drive(w, 1'b1, f, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'd0, '0, '0);
    lat = 0;
    rdy_seen = rd(w);
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (ov(w)) break;
      rdy_seen |= rd(w);
    end
    r = res(w);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold out_valid", 64'(ov(w)), 64'd1);
      check("hold result", res(w), r);
      check("hold in_ready", 64'(rd(w)), 64'd0);
    end
    @(negedge clk);
    set_oready(w, 1'b1);
    @(posedge clk); #1;
    set_oready(w, 1'b0);
    check("post-handshake out_valid", 64'(ov(w)), 64'd0);
    check("post-handshake in_ready", 64'(rd(w)), 64'd1);
  endtask

  initial begin
    logic [63:0] r, a, b;
    logic [2:0]  f;
    int          lat;
    logic        rs, saw;

    drive(32, 1'b0, 3'd0, '0, '0);
    drive(64, 1'b0, 3'd0, '0, '0);
    set_flush(32, 1'b0); set_flush(64, 1'b0);
    set_oready(32, 1'b0); set_oready(64, 1'b0);
    reset = 1'b0;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34});
    vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,        34});
    vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,         34});
    vecs.push_back('{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 2});
    vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5,         2});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2});
    vecs.push_back('{3'd0, 32'd0,          32'd123,        32'd0,         2});
    vecs.push_back('{3'd3, 32'd5,          32'd0,          32'd0,         2});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset out_valid", 64'(ov(32)), 64'd0);
    check("reset result", res(32), 64'd0);
    check("reset busy", 64'(bsy(32)), 64'd0);
    check("reset in_ready", 64'(rd(32)), 64'd1);
    check("reset result64", res(64), 64'd0);

    foreach (vecs[i]) begin
      run(32, vecs[i].f, {32'b0, vecs[i].a}, {32'b0, vecs[i].b}, 0, r, lat, rs);
      check($sformatf("vec%0d result", i), r, {32'b0, vecs[i].exp});
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d in_ready while busy", i), 64'(rs), 64'd0);
    end

    // Backpressure, then an immediately following request.
    run(32, 3'd0, 64'd3, 64'd5, 5, r, lat, rs);
    check("bp result", r, 64'd15);
    check("bp latency", 64'(lat), 64'd34);
    run(32, 3'd5, 64'd100, 64'd7, 0, r, lat, rs);
    check("after bp result", r, 64'd14);
    check("after bp latency", 64'(lat), 64'd34);

    // flush together with in_valid in IDLE: not accepted.
    @(negedge clk);
    drive(32, 1'b1, 3'd0, 64'd3, 64'd5);
    set_flush(32, 1'b1);
    @(posedge clk); #1;
    check("flush+valid in_ready", 64'(rd(32)), 64'd1);
    check("flush+valid busy", 64'(bsy(32)), 64'd0);
    drive(32, 1'b0, 3'd0, '0, '0);
    set_flush(32, 1'b0);

    // flush at CALC iteration 10.
    @(negedge clk);
    drive(32, 1'b1, 3'd0, 64'd9, 64'd9);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, '0, '0);
    check("pre-flush busy", 64'(bsy(32)), 64'd1);
    repeat (9) @(posedge clk);
    #1 set_flush(32, 1'b1);
    @(posedge clk); #1;
    set_flush(32, 1'b0);
    check("flush in_ready", 64'(rd(32)), 64'd1);
    check("flush busy", 64'(bsy(32)), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw |= ov(32);
    end
    check("flush no out_valid", 64'(saw), 64'd0);

    run(32, 3'd0, 64'd6, 64'd7, 0, r, lat, rs);
    check("post-flush result", r, 64'd42);

    // Reset asserted mid-CALC.
    @(negedge clk);
    drive(32, 1'b1, 3'd4, 64'd1000, 64'd7);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, '0, '0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid reset out_valid", 64'(ov(32)), 64'd0);
    check("mid reset result", res(32), 64'd0);
    check("mid reset busy", 64'(bsy(32)), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run(32, 3'd4, 64'd1000, 64'd7, 0, r, lat, rs);
    check("post-reset result", r, 64'd142);

    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rand_opnd(32);
      b = rand_opnd(32);
      run(32, f, a, b, 0, r, lat, rs);
      check($sformatf("rand32[%0d] f=%0d a=%0h b=%0h result", i, f, a, b), r, model(32, f, a, b));
      check($sformatf("rand32[%0d] latency", i), 64'(lat), 64'(exp_lat(32, f, a, b)));
    end

    // DATA_W = 64.
    run(64, 3'd0, 64'h1 << 40, 64'd3, 0, r, lat, rs);
    check("w64 mul result", r, 64'h0000_0300_0000_0000);
    check("w64 mul latency", 64'(lat), 64'd66);
    check("w64 in_ready while busy", 64'(rs), 64'd0);

    @(negedge clk);
    drive(64, 1'b1, 3'd4, 64'd12345, 64'd17);
    @(posedge clk); #1;
    drive(64, 1'b0, 3'd0, '0, '0);
    repeat (9) @(posedge clk);
    #1 set_flush(64, 1'b1);
    @(posedge clk); #1;
    set_flush(64, 1'b0);
    check("w64 flush in_ready", 64'(rd(64)), 64'd1);
    saw = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      saw |= ov(64);
    end
    check("w64 flush no out_valid", 64'(saw), 64'd0);

    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rand_opnd(64);
      b = rand_opnd(64);
      run(64, f, a, b, 0, r, lat, rs);
      check($sformatf("rand64[%0d] f=%0d a=%0h b=%0h result", i, f, a, b), r, model(64, f, a, b));
      check($sformatf("rand64[%0d] latency", i), 64'(lat), 64'(exp_lat(64, f, a, b)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
